// File: rtl/pq_pkg.sv
// Shared types for the priority-queue master and the max_priority_queue it drives.
package pq_pkg;

  typedef enum logic [1:0] {
    PQ_NOP  = 2'b00,
    PQ_PUSH = 2'b01,
    PQ_POP  = 2'b10,
    PQ_TOP  = 2'b11
  } pq_op_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    DRAIN
  } pq_sm_state_e;

endpackage

// File: rtl/pq_gap_counter.sv
// Loadable down-counter that enforces idle cycles between queue operations.
// Counts down to zero and stays there until reloaded.
module pq_gap_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  // Reload on request, otherwise count down and saturate at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pq_sort_master.sv
// Batch sorter front-end: pushes an upstream batch into a max priority queue, waits for the
// queue to settle, then pops the words out largest-first onto a downstream stream.
module pq_sort_master
  import pq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PQ_DEPTH   = 8,
  parameter int unsigned POP_GAP    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] pq_data_in,
  output logic                  pq_valid_in,
  output logic [1:0]            pq_op,
  input  logic                  pq_ready_out,
  input  logic [DATA_WIDTH-1:0] pq_out,
  input  logic                  pq_valid_out,
  output logic                  pq_ready_in,
  output logic                  busy,
  output logic                  overflow
);

  localparam int unsigned CW = $clog2(PQ_DEPTH + 1);
  localparam int unsigned GW = $clog2(POP_GAP + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(PQ_DEPTH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [GW-1:0] GAP_C    = GW'(POP_GAP);
  // SETTLE is entered one cycle after the last PUSH, so it needs one less count.
  localparam logic [GW-1:0] GAP_M1_C = GW'(POP_GAP - 1);

  pq_sm_state_e          r_state;
  logic [CW-1:0]         r_load_cnt;
  logic [CW-1:0]         r_pop_cnt;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_valid;
  logic                  r_m_last;
  logic                  r_overflow;

  logic          w_accept;
  logic          w_close;
  logic          w_out_free;
  logic          w_pop;
  logic          w_gap_zero;
  logic          w_gap_load;
  logic [GW-1:0] w_gap_value;

  assign s_ready = !reset && ((r_state == IDLE) || (r_state == LOAD)) && pq_ready_out &&
                   (r_load_cnt < DEPTH_C);
  assign w_accept = s_valid && s_ready;
  // A batch closes on s_last or when the queue capacity is reached.
  assign w_close = w_accept && (s_last || ((r_load_cnt + ONE_C) == DEPTH_C));
  assign w_out_free = !r_m_valid || m_ready;
  assign w_pop = !reset && (r_state == DRAIN) && w_gap_zero && pq_valid_out && w_out_free &&
                 (r_pop_cnt < r_load_cnt);

  assign w_gap_load  = w_close || w_pop;
  assign w_gap_value = w_pop ? GAP_C : GAP_M1_C;

  pq_gap_counter #(
    .WIDTH (GW)
  ) u_gap (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_gap_load),
    .i_value (w_gap_value),
    .o_zero  (w_gap_zero)
  );

  // Queue command bus: PUSH follows the upstream handshake, POP the drain condition.
  always_comb begin
    pq_op       = PQ_NOP;
    pq_valid_in = 1'b0;
    pq_data_in  = '0;
    pq_ready_in = 1'b0;
    if (w_accept) begin
      pq_op       = PQ_PUSH;
      pq_valid_in = 1'b1;
      pq_data_in  = s_data;
    end else if (w_pop) begin
      pq_op       = PQ_POP;
      pq_ready_in = 1'b1;
    end
  end

  // Batch FSM with load/pop counters and the registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_load_cnt <= '0;
      r_pop_cnt  <= '0;
      r_m_data   <= '0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_accept && !s_last && ((r_load_cnt + ONE_C) == DEPTH_C);
      if (w_accept) begin
        r_load_cnt <= r_load_cnt + ONE_C;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) r_state <= w_close ? SETTLE : LOAD;
        end
        LOAD: begin
          if (w_close) r_state <= SETTLE;
        end
        SETTLE: begin
          if (w_gap_zero) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_pop) begin
            r_m_data  <= pq_out;
            r_m_valid <= 1'b1;
            r_m_last  <= ((r_pop_cnt + ONE_C) == r_load_cnt);
            r_pop_cnt <= r_pop_cnt + ONE_C;
          end else if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            if (r_m_last) begin
              r_state    <= IDLE;
              r_load_cnt <= '0;
              r_pop_cnt  <= '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_data   = r_m_data;
  assign m_valid  = r_m_valid;
  assign m_last   = r_m_last;
  assign busy     = (r_state != IDLE);
  assign overflow = r_overflow;

endmodule
